// File: rtl/frame_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_seq_pkg
//  Description : Shared types and constants for the frame sequencer: game and
//                sequencer state encodings, status bit indices, default keys.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_seq_pkg;

    typedef enum logic [1:0] {
        GAME_TITLE    = 2'd0,
        GAME_PAUSED   = 2'd1,
        GAME_PLAYING  = 2'd2,
        GAME_GAMEOVER = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_END   = 2'd3
    } seq_state_t;

    localparam int STAT_TITLE    = 0;
    localparam int STAT_PAUSED   = 1;
    localparam int STAT_PLAYING  = 2;
    localparam int STAT_GAMEOVER = 3;

    localparam logic [7:0] KEY_START_DEFAULT = 8'h2C;
    localparam logic [7:0] KEY_PAUSE_DEFAULT = 8'h13;

    // One-hot status word for a game state.
    function automatic logic [3:0] status_onehot(input game_state_t g);
        logic [3:0] s;
        s = '0;
        case (g)
            GAME_TITLE:    s[STAT_TITLE]    = 1'b1;
            GAME_PAUSED:   s[STAT_PAUSED]   = 1'b1;
            GAME_PLAYING:  s[STAT_PLAYING]  = 1'b1;
            default:       s[STAT_GAMEOVER] = 1'b1;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_sync
//  Description : Brings VGA_VS into the system clock domain through two flops
//                and emits a registered one-cycle pulse on its rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_clk,
    output logic o_frame_tick
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_prev_q;
    logic r_tick_q;

    // Two-flop synchroniser, previous-value flop and registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
            r_prev_q <= 1'b0;
            r_tick_q <= 1'b0;
        end else begin
            r_meta_q <= i_frame_clk;
            r_sync_q <= r_meta_q;
            r_prev_q <= r_sync_q;
            r_tick_q <= r_sync_q & ~r_prev_q;
        end
    end

    assign o_frame_tick = r_tick_q;

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : Per-frame scheduler. Applies latched key presses to the game
//                state on each frame tick, then issues handshaked start pulses
//                to the update stages in order while PLAYING.
//                Optional: FRAME_SEQ_WATCHDOG_EN adds a per-stage watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int         NUM_STAGES    = 4,
    parameter int         FRAME_CNT_W   = 12,
    parameter int         STAGE_TIMEOUT = 1023,
    parameter logic [7:0] KEY_START     = KEY_START_DEFAULT,
    parameter logic [7:0] KEY_PAUSE     = KEY_PAUSE_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset_N,
    input  logic                   frame_clk,
    input  logic [7:0]             keycode,
    input  logic                   collision,
    input  logic [NUM_STAGES-1:0]  stage_done,
    output logic [NUM_STAGES-1:0]  stage_go,
    output logic [3:0]             status,
    output logic                   game_clear,
    output logic [FRAME_CNT_W-1:0] frame_counter,
    output logic                   seq_busy,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

    logic                   w_frame_tick;
    logic                   w_wd_expire;
    logic                   w_start_press;
    logic                   w_pause_press;
    logic                   w_tick_accept;
    logic [STG_W-1:0]       w_next_idx;

    game_state_t            r_game_q,       r_game_d;
    seq_state_t             r_seq_q,        r_seq_d;
    logic [STG_W-1:0]       r_idx_q,        r_idx_d;
    logic [NUM_STAGES-1:0]  r_stage_go_q,   r_stage_go_d;
    logic [3:0]             r_status_q,     r_status_d;
    logic                   r_clear_q,      r_clear_d;
    logic [FRAME_CNT_W-1:0] r_frame_cnt_q,  r_frame_cnt_d;
    logic                   r_busy_q,       r_busy_d;
    logic                   r_overrun_q,    r_overrun_d;
    logic                   r_start_pend_q, r_start_pend_d;
    logic                   r_pause_pend_q, r_pause_pend_d;
    logic [7:0]             r_key_prev_q,   r_key_prev_d;

    frame_tick_sync u_tick_sync (
        .clk          (Clk),
        .rst_n        (Reset_N),
        .i_frame_clk  (frame_clk),
        .o_frame_tick (w_frame_tick)
    );

    assign w_start_press = (keycode == KEY_START) && (r_key_prev_q != KEY_START);
    assign w_pause_press = (keycode == KEY_PAUSE) && (r_key_prev_q != KEY_PAUSE);
    // A tick arriving mid-sequence is dropped entirely, including key handling.
    assign w_tick_accept = w_frame_tick && (r_seq_q == SEQ_IDLE);
    assign w_next_idx    = r_idx_q + STG_W'(1);

    // Next-state logic for the game FSM, key latches and stage sequencer.
    always_comb begin
        r_game_d       = r_game_q;
        r_seq_d        = r_seq_q;
        r_idx_d        = r_idx_q;
        r_stage_go_d   = '0;
        r_clear_d      = 1'b0;
        r_frame_cnt_d  = r_frame_cnt_q;
        r_busy_d       = r_busy_q;
        r_overrun_d    = r_overrun_q;
        r_start_pend_d = r_start_pend_q;
        r_pause_pend_d = r_pause_pend_q;
        r_key_prev_d   = keycode;

        if (w_frame_tick && (r_seq_q != SEQ_IDLE)) begin
            r_overrun_d = 1'b1;
        end

        if (w_tick_accept) begin
            r_start_pend_d = 1'b0;
            r_pause_pend_d = 1'b0;
            case (r_game_q)
                GAME_TITLE: begin
                    if (r_start_pend_q) begin
                        r_game_d      = GAME_PLAYING;
                        r_clear_d     = 1'b1;
                        r_frame_cnt_d = '0;
                    end
                end
                GAME_PLAYING: begin
                    if (r_pause_pend_q) r_game_d = GAME_PAUSED;
                end
                GAME_PAUSED: begin
                    if (r_pause_pend_q) r_game_d = GAME_PLAYING;
                end
                default: begin
                    if (r_start_pend_q) begin
                        r_game_d  = GAME_TITLE;
                        r_clear_d = 1'b1;
                    end
                end
            endcase
            if (r_game_d == GAME_PLAYING) begin
                r_seq_d         = SEQ_ISSUE;
                r_idx_d         = '0;
                r_stage_go_d[0] = 1'b1;
                r_busy_d        = 1'b1;
            end
        end

        case (r_seq_q)
            SEQ_ISSUE: r_seq_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (stage_done[r_idx_q] || w_wd_expire) begin
                    if (r_idx_q == LAST_STAGE) begin
                        r_seq_d = SEQ_END;
                    end else begin
                        r_seq_d                  = SEQ_ISSUE;
                        r_idx_d                  = w_next_idx;
                        r_stage_go_d[w_next_idx] = 1'b1;
                    end
                end
            end
            SEQ_END: begin
                r_seq_d       = SEQ_IDLE;
                r_busy_d      = 1'b0;
                r_frame_cnt_d = r_frame_cnt_q + FRAME_CNT_W'(1);
                if (collision) begin
                    r_game_d       = GAME_GAMEOVER;
                    r_start_pend_d = 1'b0;
                    r_pause_pend_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Presses are latched last so a press is never lost to a same-cycle clear.
        if (w_start_press) r_start_pend_d = 1'b1;
        if (w_pause_press) r_pause_pend_d = 1'b1;

        r_status_d = status_onehot(r_game_d);
    end

    // State and registered outputs; async reset drops everything at once.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_game_q       <= GAME_TITLE;
            r_seq_q        <= SEQ_IDLE;
            r_idx_q        <= '0;
            r_stage_go_q   <= '0;
            r_status_q     <= 4'b0001;
            r_clear_q      <= 1'b0;
            r_frame_cnt_q  <= '0;
            r_busy_q       <= 1'b0;
            r_overrun_q    <= 1'b0;
            r_start_pend_q <= 1'b0;
            r_pause_pend_q <= 1'b0;
            r_key_prev_q   <= '0;
        end else begin
            r_game_q       <= r_game_d;
            r_seq_q        <= r_seq_d;
            r_idx_q        <= r_idx_d;
            r_stage_go_q   <= r_stage_go_d;
            r_status_q     <= r_status_d;
            r_clear_q      <= r_clear_d;
            r_frame_cnt_q  <= r_frame_cnt_d;
            r_busy_q       <= r_busy_d;
            r_overrun_q    <= r_overrun_d;
            r_start_pend_q <= r_start_pend_d;
            r_pause_pend_q <= r_pause_pend_d;
            r_key_prev_q   <= r_key_prev_d;
        end
    end

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(STAGE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STAGE_TIMEOUT);

    logic [WD_W-1:0] r_wd_cnt_q,  r_wd_cnt_d;
    logic            r_timeout_q, r_timeout_d;

    // Expires once STAGE_TIMEOUT cycles have passed since the stage's go pulse.
    assign w_wd_expire = (r_seq_q == SEQ_WAIT) && (r_wd_cnt_q >= WD_LIMIT);

    // Per-stage cycle counter, restarted by every go pulse; saturates at the limit.
    always_comb begin
        r_wd_cnt_d  = r_wd_cnt_q;
        r_timeout_d = r_timeout_q;
        if (r_stage_go_d != '0) begin
            r_wd_cnt_d = '0;
        end else if (r_wd_cnt_q < WD_LIMIT) begin
            r_wd_cnt_d = r_wd_cnt_q + WD_W'(1);
        end
        if (w_wd_expire && !stage_done[r_idx_q]) begin
            r_timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_wd_cnt_q  <= '0;
            r_timeout_q <= 1'b0;
        end else begin
            r_wd_cnt_q  <= r_wd_cnt_d;
            r_timeout_q <= r_timeout_d;
        end
    end

    assign timeout_err = r_timeout_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |STAGE_TIMEOUT;
    assign w_wd_expire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign stage_go      = r_stage_go_q;
    assign status        = r_status_q;
    assign game_clear    = r_clear_q;
    assign frame_counter = r_frame_cnt_q;
    assign seq_busy      = r_busy_q;
    assign overrun       = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Scoreboard bench for frame_sequencer. Stimulus pushes the
//                expected go/clear events; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        collision;
    logic [3:0]  stage_done;
    logic [3:0]  stage_go;
    logic [3:0]  status;
    logic        game_clear;
    logic [11:0] frame_counter;
    logic        seq_busy;
    logic        overrun;
    logic        timeout_err;

    frame_sequencer dut (
        .Clk           (Clk),
        .Reset_N       (Reset_N),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .collision     (collision),
        .stage_done    (stage_done),
        .stage_go      (stage_go),
        .status        (status),
        .game_clear    (game_clear),
        .frame_counter (frame_counter),
        .seq_busy      (seq_busy),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       clr;
        logic [3:0] go;
        logic [3:0] stat;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] hold_mask   = 4'b0000;
    logic [3:0] manual_done = 4'b0000;
    logic [3:0] resp_pend   = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_clr(input logic [3:0] st);
        exp_q.push_back('{clr: 1'b1, go: 4'b0000, stat: st});
    endtask

    task automatic push_go(input int i);
        exp_q.push_back('{clr: 1'b0, go: 4'(1 << i), stat: 4'b0100});
    endtask

    task automatic push_gos(input int first, input int last);
        for (int i = first; i <= last; i++) push_go(i);
    endtask

    task automatic score(input ev_t act, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event %0h, none expected", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(act), 32'(e));
        end
    endtask

    // Monitor: every clear pulse or go pulse must match the next expected event.
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset_N === 1'b1) begin
                if (game_clear === 1'b1) score('{clr: 1'b1, go: 4'b0000, stat: status}, "clear_event");
                if (stage_go !== 4'b0000) score('{clr: 1'b0, go: stage_go, stat: status}, "go_event");
            end
        end
    end

    // Stage model: answers each go with done one cycle later unless held.
    initial begin
        stage_done = 4'b0000;
        forever begin
            @(negedge Clk);
            stage_done = (resp_pend & ~hold_mask) | manual_done;
            resp_pend  = stage_go;
        end
    end

    task automatic press(input logic [7:0] k);
        @(negedge Clk) keycode = k;
        repeat (2) @(negedge Clk);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic frame(input int low_cyc, input logic [7:0] midkey);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        for (int i = 0; i < low_cyc; i++) begin
            @(negedge Clk);
            if (midkey != 8'h00 && i == 2) keycode = midkey;
            if (i == 4) keycode = 8'h00;
        end
    endtask

    task automatic pulse_done(input logic [3:0] m);
        @(negedge Clk) manual_done = m;
        repeat (2) @(negedge Clk);
        manual_done = 4'b0000;
        repeat (12) @(negedge Clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        Reset_N   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        collision = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_status", 32'(status), 32'h1);
        check("rst_stage_go", 32'(stage_go), 32'h0);
        check("rst_clear", 32'(game_clear), 32'h0);
        check("rst_counter", 32'(frame_counter), 32'h0);
        check("rst_busy", 32'(seq_busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        Reset_N = 1'b1;

        // Start from TITLE: clear pulse, then four stages in order.
        press(8'h2C);
        push_clr(4'b0100);
        push_gos(0, 3);
        frame(14, 8'h00);
        check("t1_status", 32'(status), 32'h4);
        check("t1_counter", 32'(frame_counter), 32'd1);
        check("t1_busy", 32'(seq_busy), 32'h0);

        // Collision in SEQ_END ends the game; no stages while GAMEOVER.
        collision = 1'b1;
        push_gos(0, 3);
        frame(14, 8'h00);
        collision = 1'b0;
        check("t2_gameover", 32'(status), 32'h8);
        check("t2_counter", 32'(frame_counter), 32'd2);
        frame(14, 8'h00);
        check("t2_still_over", 32'(status), 32'h8);
        check("t2_counter_frozen", 32'(frame_counter), 32'd2);
        press(8'h2C);
        push_clr(4'b0001);
        frame(14, 8'h00);
        check("t2_title", 32'(status), 32'h1);
        press(8'h2C);
        push_clr(4'b0100);
        push_gos(0, 3);
        frame(14, 8'h00);
        check("t2_restart_counter", 32'(frame_counter), 32'd1);

        // Pause pressed mid-sequence takes effect on the following frame.
        push_gos(0, 3);
        frame(14, 8'h13);
        check("t3_still_playing", 32'(status), 32'h4);
        check("t3_counter", 32'(frame_counter), 32'd2);
        frame(14, 8'h00);
        check("t3_paused", 32'(status), 32'h2);
        check("t3_counter_frozen", 32'(frame_counter), 32'd2);
        press(8'h13);
        push_gos(0, 3);
        frame(14, 8'h00);
        check("t3_resumed", 32'(status), 32'h4);
        check("t3_counter_resume", 32'(frame_counter), 32'd3);

        // Overrun: stage 1 stalls, a second tick arrives and is dropped.
        hold_mask = 4'b0010;
        push_gos(0, 1);
        frame(14, 8'h00);
        check("t4_busy", 32'(seq_busy), 32'h1);
        frame(14, 8'h00);
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_counter_held", 32'(frame_counter), 32'd3);
        hold_mask = 4'b0000;
        push_gos(2, 3);
        pulse_done(4'b0010);
        check("t4_counter", 32'(frame_counter), 32'd4);
        check("t4_idle", 32'(seq_busy), 32'h0);
        check("t4_overrun_sticky", 32'(overrun), 32'h1);

        // Stage 2 never completes.
        hold_mask = 4'b0100;
        push_gos(0, 2);
`ifdef FRAME_SEQ_WATCHDOG_EN
        push_go(3);
        frame(14, 8'h00);
        repeat (1100) @(negedge Clk);
        check("t5_timeout", 32'(timeout_err), 32'h1);
        check("t5_counter", 32'(frame_counter), 32'd5);
        hold_mask = 4'b0000;
`else
        frame(14, 8'h00);
        repeat (1100) @(negedge Clk);
        check("t5_no_timeout", 32'(timeout_err), 32'h0);
        check("t5_stalled", 32'(seq_busy), 32'h1);
        check("t5_counter_stalled", 32'(frame_counter), 32'd4);
        hold_mask = 4'b0000;
        push_go(3);
        pulse_done(4'b0100);
        check("t5_counter", 32'(frame_counter), 32'd5);
`endif

        // Counter wrap: run up to 12'hFFF, then one more frame.
        for (int f = 0; f < 4090; f++) begin
            push_gos(0, 3);
            frame(10, 8'h00);
        end
        check("t6_counter_max", 32'(frame_counter), 32'hFFF);
        push_gos(0, 3);
        frame(10, 8'h00);
        check("t6_counter_wrap", 32'(frame_counter), 32'h000);

        // Async reset while waiting on stage 2, with a start press pending.
        hold_mask = 4'b0100;
        push_gos(0, 2);
        found = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i == 2) frame_clk = 1'b0;
            if (stage_go[2] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        frame_clk = 1'b0;
        check("t6_go2_seen", 32'(found), 32'h1);
        @(negedge Clk) keycode = 8'h2C;
        @(negedge Clk) keycode = 8'h00;
        #2 Reset_N = 1'b0;
        #1;
        check("t6_rst_stage_go", 32'(stage_go), 32'h0);
        check("t6_rst_status", 32'(status), 32'h1);
        check("t6_rst_busy", 32'(seq_busy), 32'h0);
        check("t6_rst_overrun", 32'(overrun), 32'h0);
        check("t6_rst_clear", 32'(game_clear), 32'h0);
        check("t6_rst_counter", 32'(frame_counter), 32'h0);
        check("t6_rst_timeout", 32'(timeout_err), 32'h0);
        hold_mask = 4'b0000;
        repeat (3) @(negedge Clk);
        Reset_N = 1'b1;
        frame(14, 8'h00);
        check("t6_key_discarded", 32'(status), 32'h1);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
